// File: rtl/log_capture.sv
// Tx-sample log capture: records {I,Q} words into a block RAM after a run_log rising edge and reads them back when idle.
// Optional macro LOG_CAPTURE_TSTAMP_EN puts a 16-bit sample counter in the upper field of each word.
module log_capture #(
  parameter int NB_SAMPLE = 8,
  parameter int NB_ADDR   = 15,
  parameter int NB_WORD   = 32
) (
  input  logic                 clk,
  input  logic                 i_rstn,
  input  logic                 i_run_log,
  input  logic                 i_read_log,
  input  logic [NB_ADDR-1:0]   i_addr_log,
  input  logic                 i_valid,
  input  logic [NB_SAMPLE-1:0] i_data_I,
  input  logic [NB_SAMPLE-1:0] i_data_Q,
  output logic [NB_WORD-1:0]   o_data_log,
  output logic                 o_mem_full
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  state_t               state;
  logic                 run_log_p0;
  logic [NB_ADDR-1:0]   wr_addr;
  logic                 start;
  logic                 wr_en;
  logic [15:0]          stamp;
  logic [NB_WORD-1:0]   log_word;
  logic [NB_WORD-1:0]   mem [2**NB_ADDR];

  // A start event wins over a coincident sample, so that sample is dropped.
  assign start = i_run_log & ~run_log_p0;
  assign wr_en = i_rstn & (state == CAPTURE) & i_valid & ~start;

`ifdef LOG_CAPTURE_TSTAMP_EN
  logic [15:0] smp_cnt;

  always_ff @(posedge clk) begin
    if (!i_rstn)    smp_cnt <= '0;
    else if (start) smp_cnt <= '0;
    else if (wr_en) smp_cnt <= smp_cnt + 16'd1;
  end

  assign stamp = smp_cnt;
`else
  assign stamp = '0;
`endif

  always_comb begin
    log_word = '0;
    log_word[2*NB_SAMPLE-1:0] = {i_data_I, i_data_Q};
    log_word[NB_WORD-1 -: 16] = stamp;
  end

  always_ff @(posedge clk) begin
    if (!i_rstn) begin
      state      <= IDLE;
      wr_addr    <= '0;
      o_mem_full <= 1'b0;
      run_log_p0 <= 1'b0;
      o_data_log <= '0;
    end else begin
      run_log_p0 <= i_run_log;
      if (start) begin
        state      <= CAPTURE;
        wr_addr    <= '0;
        o_mem_full <= 1'b0;
      end else begin
        case (state)
          CAPTURE: begin
            if (i_valid) begin
              // Last address ends the capture; the pointer never wraps.
              if (wr_addr == LAST_ADDR) begin
                state      <= FULL;
                o_mem_full <= 1'b1;
              end else begin
                wr_addr <= wr_addr + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      if (i_read_log && (state != CAPTURE))
        o_data_log <= mem[i_addr_log];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= log_word;
  end

endmodule
